nn_argmax: RTL and testbench

//   Classification stage directly downstream of the NN accelerator. Waits for the accelerator's

---
 rtl/nn_argmax.sv | 192 +++++++++++++++++++
 tb/tb_nn_argmax.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/nn_argmax.sv
// Serial argmax over NUM_CLASSES signed scores, with a valid/ack result handshake.
// Optional runner-up index and margin tracking is built when ARGMAX_MARGIN_EN is defined.
module nn_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ready_i,
    input  logic [NUM_CLASSES*DATA_W-1:0] score_i,
    input  logic                          ack_i,
    output logic                          busy_o,
    output logic                          valid_o,
    output logic [IDX_W-1:0]              class_o,
    output logic [DATA_W-1:0]             max_o,
    output logic                          overrun_o,
    output logic [IDX_W-1:0]              second_o,
    output logic [DATA_W-1:0]             margin_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                          state_q;
    logic                            ready_q;
    logic [NUM_CLASSES*DATA_W-1:0]   buf_q;
    logic [IDX_W-1:0]                ptr_q;
    logic                            last_q;
    logic signed [DATA_W-1:0]        best_q;
    logic [IDX_W-1:0]                best_idx_q;
    logic                            busy_q;
    logic                            valid_q;
    logic [IDX_W-1:0]                class_q;
    logic [DATA_W-1:0]               max_q;
    logic                            overrun_q;

    logic                            rise_s;
    logic signed [DATA_W-1:0]        cand_s;
    logic signed [DATA_W-1:0]        best_d;
    logic [IDX_W-1:0]                best_idx_d;

`ifdef ARGMAX_MARGIN_EN
    logic signed [DATA_W-1:0]        second_q;
    logic [IDX_W-1:0]                second_idx_q;
    logic signed [DATA_W-1:0]        second_d;
    logic [IDX_W-1:0]                second_idx_d;
    logic [IDX_W-1:0]                second_out_q;
    logic [DATA_W-1:0]               margin_q;
    logic [DATA_W:0]                 margin_full_s;
`endif

    assign rise_s = ready_i & ~ready_q;
    assign cand_s = signed'(buf_q[ptr_q*DATA_W +: DATA_W]);

    // One signed compare step; ties keep the earlier (lower) index.
    always_comb begin
        best_d     = best_q;
        best_idx_d = best_idx_q;
`ifdef ARGMAX_MARGIN_EN
        second_d     = second_q;
        second_idx_d = second_idx_q;
`endif
        if (cand_s > best_q) begin
            best_d     = cand_s;
            best_idx_d = ptr_q;
`ifdef ARGMAX_MARGIN_EN
            second_d     = best_q;
            second_idx_d = best_idx_q;
`endif
        end else begin
`ifdef ARGMAX_MARGIN_EN
            if (cand_s > second_q) begin
                second_d     = cand_s;
                second_idx_d = ptr_q;
            end else begin
                second_d     = second_q;
                second_idx_d = second_idx_q;
            end
`else
            best_d     = best_q;
            best_idx_d = best_idx_q;
`endif
        end
    end

`ifdef ARGMAX_MARGIN_EN
    // Difference taken one bit wider so it can never wrap; it always fits DATA_W unsigned.
    assign margin_full_s = {best_q[DATA_W-1], best_q} - {second_q[DATA_W-1], second_q};
`endif

    // Control FSM, scan datapath and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            buf_q      <= '0;
            ptr_q      <= '0;
            last_q     <= 1'b0;
            best_q     <= '0;
            best_idx_q <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            class_q    <= '0;
            max_q      <= '0;
            overrun_q  <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
            second_q     <= '0;
            second_idx_q <= '0;
            second_out_q <= '0;
            margin_q     <= '0;
`endif
        end else begin
            ready_q <= ready_i;
            case (state_q)
                ST_IDLE: begin
                    if (rise_s) begin
                        buf_q      <= score_i;
                        best_q     <= signed'(score_i[DATA_W-1:0]);
                        best_idx_q <= '0;
                        ptr_q      <= IDX_W'(1);
                        last_q     <= 1'b0;
                        busy_q     <= 1'b1;
`ifdef ARGMAX_MARGIN_EN
                        second_q     <= {1'b1, {(DATA_W-1){1'b0}}};
                        second_idx_q <= IDX_W'(1);
`endif
                        state_q    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (rise_s) begin
                        overrun_q <= 1'b1;
                    end
                    // Extra publish edge after the last compare gives NUM_CLASSES-edge latency.
                    if (last_q) begin
                        class_q <= best_idx_q;
                        max_q   <= best_q;
                        valid_q <= 1'b1;
`ifdef ARGMAX_MARGIN_EN
                        second_out_q <= second_idx_q;
                        margin_q     <= margin_full_s[DATA_W-1:0];
`endif
                        state_q <= ST_HOLD;
                    end else begin
                        best_q     <= best_d;
                        best_idx_q <= best_idx_d;
`ifdef ARGMAX_MARGIN_EN
                        second_q     <= second_d;
                        second_idx_q <= second_idx_d;
`endif
                        if (ptr_q == IDX_W'(NUM_CLASSES - 1)) begin
                            last_q <= 1'b1;
                        end else begin
                            ptr_q <= ptr_q + IDX_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (rise_s) begin
                        overrun_q <= 1'b1;
                    end
                    if (ack_i) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign valid_o   = valid_q;
    assign class_o   = class_q;
    assign max_o     = max_q;
    assign overrun_o = overrun_q;
`ifdef ARGMAX_MARGIN_EN
    assign second_o  = second_out_q;
    assign margin_o  = margin_q;
`else
    assign second_o  = '0;
    assign margin_o  = '0;
`endif

endmodule

// File: tb/tb_nn_argmax.sv
// Directed self-checking bench for nn_argmax; expected values are hand-computed.
module tb_nn_argmax;

    localparam int N  = 10;
    localparam int DW = 32;
    localparam int IW = 4;

    logic            clk;
    logic            reset;
    logic            ready_i;
    logic [N*DW-1:0] score_i;
    logic            ack_i;
    logic            busy_o;
    logic            valid_o;
    logic [IW-1:0]   class_o;
    logic [DW-1:0]   max_o;
    logic            overrun_o;
    logic [IW-1:0]   second_o;
    logic [DW-1:0]   margin_o;

    int err_cnt;
    int chk_cnt;
    int sc[N];

    nn_argmax #(.NUM_CLASSES(N), .DATA_W(DW), .IDX_W(IW)) dut (
        .clk(clk), .reset(reset), .ready_i(ready_i), .score_i(score_i), .ack_i(ack_i),
        .busy_o(busy_o), .valid_o(valid_o), .class_o(class_o), .max_o(max_o),
        .overrun_o(overrun_o), .second_o(second_o), .margin_o(margin_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_scores();
        for (int k = 0; k < N; k++) begin
            score_i[k*DW +: DW] = sc[k];
        end
    endtask

    // Produces a fresh ready edge, then checks the valid_o latency exactly.
    task automatic run_scan(input string tag);
        ready_i = 1'b0;
        tick();
        ready_i = 1'b1;
        tick();
        check_eq({tag, "_busy"}, 64'(busy_o), 64'd1);
        repeat (N - 1) tick();
        check_eq({tag, "_valid_early"}, 64'(valid_o), 64'd0);
        tick();
        check_eq({tag, "_valid"}, 64'(valid_o), 64'd1);
    endtask

    task automatic check_result(input string tag, input logic [IW-1:0] cls, input logic [DW-1:0] mx,
                                input logic [IW-1:0] sec, input logic [DW-1:0] mrg);
        check_eq({tag, "_class"}, 64'(class_o), 64'(cls));
        check_eq({tag, "_max"}, 64'(max_o), 64'(mx));
`ifdef ARGMAX_MARGIN_EN
        check_eq({tag, "_second"}, 64'(second_o), 64'(sec));
        check_eq({tag, "_margin"}, 64'(margin_o), 64'(mrg));
`else
        check_eq({tag, "_second"}, 64'(second_o), 64'(0 * sec));
        check_eq({tag, "_margin"}, 64'(margin_o), 64'(0 * mrg));
`endif
    endtask

    task automatic ack_pulse(input string tag);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        check_eq({tag, "_ack_valid"}, 64'(valid_o), 64'd0);
        check_eq({tag, "_ack_busy"}, 64'(busy_o), 64'd0);
    endtask

    initial begin
        err_cnt = 0;
        chk_cnt = 0;
        reset   = 1'b1;
        ready_i = 1'b0;
        ack_i   = 1'b0;
        score_i = '0;
        #1;
        check_eq("rst_valid", 64'(valid_o), 64'd0);
        check_eq("rst_busy", 64'(busy_o), 64'd0);
        check_eq("rst_class", 64'(class_o), 64'd0);
        check_eq("rst_overrun", 64'(overrun_o), 64'd0);
        #12;
        reset = 1'b0;
        tick();

        // Test 1: tie at 100 keeps index 2.
        sc = '{5, -3, 100, 7, 100, 0, -1, 2, 3, 4};
        load_scores();
        run_scan("t1");
        check_result("t1", 4'd2, 32'd100, 4'd4, 32'd0);

        // Test 3: result stable while ack_i low and score_i changes.
        for (int i = 0; i < 5; i++) begin
            score_i = ~score_i;
            tick();
        end
        check_eq("t3_valid_hold", 64'(valid_o), 64'd1);
        check_result("t3", 4'd2, 32'd100, 4'd4, 32'd0);
        ack_pulse("t3");

        // Test 2: all negative, with ack_i asserted during the scan (must be ignored).
        sc = '{-10, -2, -5, -9, -3, -7, -8, -4, -6, -11};
        load_scores();
        ready_i = 1'b0;
        tick();
        ready_i = 1'b1;
        tick();
        ack_i = 1'b1;
        repeat (N - 1) tick();
        ack_i = 1'b0;
        check_eq("t2_valid_early", 64'(valid_o), 64'd0);
        tick();
        check_eq("t2_valid", 64'(valid_o), 64'd1);
        check_result("t2", 4'd1, 32'hFFFF_FFFE, 4'd4, 32'd1);
        ack_pulse("t2");

        // Test 4: ready rise in SCAN sets overrun and does not disturb the scan.
        sc = '{5, -3, 100, 7, 100, 0, -1, 2, 3, 4};
        load_scores();
        ready_i = 1'b0;
        tick();
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        repeat (3) tick();
        check_eq("t4_no_overrun_yet", 64'(overrun_o), 64'd0);
        ready_i = 1'b1;
        tick();
        check_eq("t4_overrun", 64'(overrun_o), 64'd1);
        repeat (N - 5) tick();
        check_eq("t4_valid_early", 64'(valid_o), 64'd0);
        tick();
        check_eq("t4_valid", 64'(valid_o), 64'd1);
        check_result("t4", 4'd2, 32'd100, 4'd4, 32'd0);
        ack_pulse("t4");
        repeat (3) tick();
        check_eq("t4_no_rescan_busy", 64'(busy_o), 64'd0);
        check_eq("t4_no_rescan_valid", 64'(valid_o), 64'd0);

        // Test 5: async reset mid-scan with ready held high, then capture on first edge.
        ready_i = 1'b0;
        tick();
        ready_i = 1'b1;
        tick();
        repeat (4) tick();
        reset = 1'b1;
        #1;
        check_eq("t5_rst_busy", 64'(busy_o), 64'd0);
        check_eq("t5_rst_overrun", 64'(overrun_o), 64'd0);
        check_eq("t5_rst_valid", 64'(valid_o), 64'd0);
        #2;
        reset = 1'b0;
        tick();
        check_eq("t5_capture_busy", 64'(busy_o), 64'd1);
        repeat (N - 1) tick();
        check_eq("t5_valid_early", 64'(valid_o), 64'd0);
        tick();
        check_eq("t5_valid", 64'(valid_o), 64'd1);
        check_result("t5", 4'd2, 32'd100, 4'd4, 32'd0);
        ack_pulse("t5");

        // Test 6: signed extremes.
        sc = '{32'h8000_0000, 0, 0, 32'h7FFF_FFFF, 0, 0, 0, 0, 0, 0};
        load_scores();
        run_scan("t6");
        check_result("t6", 4'd3, 32'h7FFF_FFFF, 4'd1, 32'h7FFF_FFFF);
        ack_pulse("t6");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
